if_fetch_unit: RTL

- Instruction-fetch stage of the 16-bit pipelined CPU.
- Owns the PC and drives it to the combinational instruction memory, which returns `inst` in the same cycle.
- Captures the instruction into the IF/ID pipeline register.
- Handles ID-stage stalls, branch redirects resolved in ID (BTEQZ/B class, no delay slot), and memory-port denials from the shared-SRAM arbiter.

---
 rtl/if_fetch_unit_if.sv | 27 ++
 rtl/if_fetch_unit.sv | 82 ++++++++
 2 files changed

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, ID-stage controls and IF/ID outputs.
// master = fetch unit, slave = memory/arbiter/ID-stage side.
interface if_fetch_unit_if #(
    parameter int PC_W   = 16,
    parameter int INST_W = 16
);
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              mem_ready;
    logic              stall;
    logic              branch_en;
    logic [PC_W-1:0]   branch_target;
    logic [PC_W-1:0]   id_pc;
    logic [INST_W-1:0] id_inst;
    logic              id_valid;
    logic [15:0]       fetch_count;

    modport master (
        output pc, id_pc, id_inst, id_valid, fetch_count,
        input  inst, mem_ready, stall, branch_en, branch_target
    );

    modport slave (
        input  pc, id_pc, id_inst, id_valid, fetch_count,
        output inst, mem_ready, stall, branch_en, branch_target
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fills the IF/ID register and
// handles stalls, ID-resolved branches and arbiter port denials.
module if_fetch_unit #(
    parameter int                PC_W     = 16,
    parameter int                INST_W   = 16,
    parameter logic [PC_W-1:0]   RESET_PC = 16'h0000,
    parameter logic [INST_W-1:0] NOP_INST = 16'h0800
) (
    input  logic              clk,
    input  logic              rst,
    if_fetch_unit_if.master   bus
);
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_WAIT} state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   id_pc_q, id_pc_d;
    logic [INST_W-1:0] id_inst_q, id_inst_d;
    logic              id_valid_q, id_valid_d;
    logic [15:0]       cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            id_pc_q    <= '0;
            id_inst_q  <= NOP_INST;
            id_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN, S_WAIT: begin
                // Redirect beats stall and denial; wrong-path word is dropped.
                if (bus.branch_en) begin
                    pc_d       = bus.branch_target;
                    id_pc_d    = bus.branch_target;
                    id_inst_d  = NOP_INST;
                    id_valid_d = 1'b0;
                    state_d    = S_RUN;
                end else if (bus.stall) begin
                    state_d = state_q;
                end else if (!bus.mem_ready) begin
                    id_pc_d    = pc_q;
                    id_inst_d  = NOP_INST;
                    id_valid_d = 1'b0;
                    state_d    = S_WAIT;
                end else begin
                    id_pc_d    = pc_q;
                    id_inst_d  = bus.inst;
                    id_valid_d = 1'b1;
                    pc_d       = pc_q + PC_W'(1);
                    cnt_d      = cnt_q + 16'd1;
                    state_d    = S_RUN;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    assign bus.pc          = pc_q;
    assign bus.id_pc       = id_pc_q;
    assign bus.id_inst     = id_inst_q;
    assign bus.id_valid    = id_valid_q;
    assign bus.fetch_count = cnt_q;
endmodule
